hazard_forward_unit: RTL and testbench

Tracks register-destination and control state for the ID/EX, EX/MEM and MEM/WB stages of the pipelined MIPS core. Produces the 2-bit forwarding selects and the stage register numbers consumed by the EX-stage forwarding multiplexer, and detects load-use hazards. On a load-use hazard it stalls PC/IF/ID and injects a bubble into ID/EX. It sits between the decode stage (its input) and the EX-stage operand forwarding mux (its output).

---
 rtl/hazard_forward_unit_pkg.sv | 23 ++
 rtl/hazard_forward_unit_fwd_select.sv | 41 ++++
 rtl/hazard_forward_unit.sv | 164 ++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit_pkg
//   Shared definitions for the EX-stage operand forwarding path.
//   The hazard/forward unit uses these, and so does the EX forwarding mux.
//   Contents:
//     REG_W_DEF  - default register-number width (5 for MIPS, 32 registers)
//     FWD_*      - operand-select encodings driven on fa/fb
//     fwd_sel_t  - 2-bit select type
// ---------------------------------------------------------------------------
package hazard_forward_unit_pkg;

  localparam int REG_W_DEF = 5;

  typedef logic [1:0] fwd_sel_t;

  // Operand comes from the ID/EX register-file read.
  localparam fwd_sel_t FWD_NONE  = 2'b00;
  // Operand comes from the MEM/WB result.
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  // Operand comes from the EX/MEM result.
  localparam fwd_sel_t FWD_EXMEM = 2'b10;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
//   Purely combinational forwarding-source selection for one EX operand.
//   The younger producer (EX/MEM) wins over the older one (MEM/WB).
//   Register 0 is hard-wired to zero, so it is never forwarded.
//   Ports:
//     srcReg     in  REG_W  source register of the instruction in ID/EX
//     emRd       in  REG_W  EX/MEM destination register
//     emRegWrite in  1      EX/MEM writes the register file
//     mwRd       in  REG_W  MEM/WB destination register
//     mwRegWrite in  1      MEM/WB writes the register file
//     sel        out 2      FWD_NONE / FWD_MEMWB / FWD_EXMEM (11 never driven)
// ---------------------------------------------------------------------------
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] srcReg,
  input  logic [REG_W-1:0] emRd,
  input  logic             emRegWrite,
  input  logic [REG_W-1:0] mwRd,
  input  logic             mwRegWrite,
  output logic [1:0]       sel
);

  logic emHit;
  logic mwHit;

  always_comb begin
    emHit = emRegWrite && (emRd != '0) && (emRd == srcReg);
    mwHit = mwRegWrite && (mwRd != '0) && (mwRd == srcReg);
    sel   = FWD_NONE;
    if (emHit) begin
      sel = FWD_EXMEM;
    end else if (mwHit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//   Holds the register-destination/control view of the ID/EX, EX/MEM and
//   MEM/WB stages, drives the EX forwarding selects, and detects load-use
//   hazards. On a load-use hazard it holds PC and IF/ID for one cycle and
//   turns the ID/EX entry into a bubble.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     dec_valid         decode holds a real instruction
//     dec_rs, dec_rt    decoded source registers
//     dec_rd            final destination (after RegDst)
//     dec_uses_rt       instruction reads rt as a source
//     dec_reg_write     instruction writes the register file
//     dec_mem_read      instruction is a load
//     flush             squash the decode instruction (taken branch/jump)
//     stall             hold PC and IF/ID this cycle
//     fa, fb            operand A/B forwarding selects
//     ie_rs, ie_rt      ID/EX source registers
//     em_rd, mw_rd      EX/MEM and MEM/WB destinations
//     em_reg_write,
//     mw_reg_write      stage write enables
//     stall_count       saturating count of stall cycles
//   Stage suffixes: _p0 = ID/EX, _p1 = EX/MEM, _p2 = MEM/WB.
// ---------------------------------------------------------------------------
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_uses_rt,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fa,
  output logic [1:0]       fb,
  output logic [REG_W-1:0] ie_rs,
  output logic [REG_W-1:0] ie_rt,
  output logic [REG_W-1:0] em_rd,
  output logic [REG_W-1:0] mw_rd,
  output logic             em_reg_write,
  output logic             mw_reg_write,
  output logic [CNT_W-1:0] stall_count
);

  // ID/EX record
  logic [REG_W-1:0] rs_p0;
  logic [REG_W-1:0] rt_p0;
  logic [REG_W-1:0] rd_p0;
  logic             regWrite_p0;
  logic             memRead_p0;
  // EX/MEM record
  logic [REG_W-1:0] rd_p1;
  logic             regWrite_p1;
  // MEM/WB record
  logic [REG_W-1:0] rd_p2;
  logic             regWrite_p2;

  logic             rsDepends;
  logic             rtDepends;
  logic             stallNow;
  logic             loadBubble;
  logic [CNT_W-1:0] stallCnt;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Load-use detection: the load in ID/EX has its data only after MEM,
  // so a consumer in decode must wait one cycle. A flushed decode slot is
  // squashed anyway, so it never needs to stall.
  always_comb begin
    rsDepends  = (rd_p0 == dec_rs);
    rtDepends  = dec_uses_rt && (rd_p0 == dec_rt);
    stallNow   = !flush && dec_valid && memRead_p0 && (rd_p0 != '0) &&
                 (rsDepends || rtDepends);
    loadBubble = flush || stallNow || !dec_valid;
  end

  // ---- decode -> ID/EX (p0) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_p0       <= '0;
      rt_p0       <= '0;
      rd_p0       <= '0;
      regWrite_p0 <= 1'b0;
      memRead_p0  <= 1'b0;
    end else if (loadBubble) begin
      rs_p0       <= '0;
      rt_p0       <= '0;
      rd_p0       <= '0;
      regWrite_p0 <= 1'b0;
      memRead_p0  <= 1'b0;
    end else begin
      rs_p0       <= dec_rs;
      // An unused rt must not match any producer, so it is parked on $0.
      rt_p0       <= dec_uses_rt ? dec_rt : '0;
      rd_p0       <= dec_rd;
      regWrite_p0 <= dec_reg_write;
      memRead_p0  <= dec_mem_read;
    end
  end

  // ---- ID/EX -> EX/MEM (p1) -> MEM/WB (p2), never stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1       <= '0;
      regWrite_p1 <= 1'b0;
      rd_p2       <= '0;
      regWrite_p2 <= 1'b0;
    end else begin
      rd_p1       <= rd_p0;
      regWrite_p1 <= regWrite_p0;
      rd_p2       <= rd_p1;
      regWrite_p2 <= regWrite_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stallNow) begin
      stallCnt <= satInc(stallCnt);
    end
  end

  fwd_select #(.REG_W(REG_W)) uFwdA (
    .srcReg     (rs_p0),
    .emRd       (rd_p1),
    .emRegWrite (regWrite_p1),
    .mwRd       (rd_p2),
    .mwRegWrite (regWrite_p2),
    .sel        (fa)
  );

  fwd_select #(.REG_W(REG_W)) uFwdB (
    .srcReg     (rt_p0),
    .emRd       (rd_p1),
    .emRegWrite (regWrite_p1),
    .mwRd       (rd_p2),
    .mwRegWrite (regWrite_p2),
    .sel        (fb)
  );

  assign stall        = stallNow;
  assign ie_rs        = rs_p0;
  assign ie_rt        = rt_p0;
  assign em_rd        = rd_p1;
  assign mw_rd        = rd_p2;
  assign em_reg_write = regWrite_p1;
  assign mw_reg_write = regWrite_p2;
  assign stall_count  = stallCnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
//   Directed and randomized stimulus for hazard_forward_unit, checked against
//   an instruction-level model of the three tracked pipeline slots.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             dec_valid = 1'b0;
  logic [REG_W-1:0] dec_rs = '0;
  logic [REG_W-1:0] dec_rt = '0;
  logic [REG_W-1:0] dec_rd = '0;
  logic             dec_uses_rt = 1'b0;
  logic             dec_reg_write = 1'b0;
  logic             dec_mem_read = 1'b0;
  logic             flush = 1'b0;
  logic             stall;
  logic [1:0]       fa;
  logic [1:0]       fb;
  logic [REG_W-1:0] ie_rs;
  logic [REG_W-1:0] ie_rt;
  logic [REG_W-1:0] em_rd;
  logic [REG_W-1:0] mw_rd;
  logic             em_reg_write;
  logic             mw_reg_write;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dec_valid     (dec_valid),
    .dec_rs        (dec_rs),
    .dec_rt        (dec_rt),
    .dec_rd        (dec_rd),
    .dec_uses_rt   (dec_uses_rt),
    .dec_reg_write (dec_reg_write),
    .dec_mem_read  (dec_mem_read),
    .flush         (flush),
    .stall         (stall),
    .fa            (fa),
    .fb            (fb),
    .ie_rs         (ie_rs),
    .ie_rt         (ie_rt),
    .em_rd         (em_rd),
    .mw_rd         (mw_rd),
    .em_reg_write  (em_reg_write),
    .mw_reg_write  (mw_reg_write),
    .stall_count   (stall_count)
  );

  // Model: slot[0] is the instruction in EX, slot[1] one stage older
  // (MEM), slot[2] two stages older (WB).
  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } instr_t;

  instr_t slot [3];
  int     cnt;
  int     total = 0;
  int     bad = 0;

  task automatic resetModel();
    for (int i = 0; i < 3; i++) slot[i] = '0;
    cnt = 0;
  endtask

  // Nearest older writer of src supplies the operand; distance 1 is the
  // EX/MEM result, distance 2 the MEM/WB result.
  function automatic logic [1:0] expSel(input logic [REG_W-1:0] src);
    for (int d = 1; d <= 2; d++) begin
      if (slot[d].wr && slot[d].rd != 0 && slot[d].rd == src)
        return (d == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic expStall();
    if (flush || !dec_valid || !slot[0].ld || slot[0].rd == 0) return 1'b0;
    if (slot[0].rd == dec_rs) return 1'b1;
    if (dec_uses_rt && slot[0].rd == dec_rt) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("stall", 32'(stall), 32'(expStall()));
    chk("fa", 32'(fa), 32'(expSel(slot[0].rs)));
    chk("fb", 32'(fb), 32'(expSel(slot[0].rt)));
    chk("ie_rs", 32'(ie_rs), 32'(slot[0].rs));
    chk("ie_rt", 32'(ie_rt), 32'(slot[0].rt));
    chk("em_rd", 32'(em_rd), 32'(slot[1].rd));
    chk("mw_rd", 32'(mw_rd), 32'(slot[2].rd));
    chk("em_reg_write", 32'(em_reg_write), 32'(slot[1].wr));
    chk("mw_reg_write", 32'(mw_reg_write), 32'(slot[2].wr));
    chk("stall_count", 32'(stall_count), 32'(cnt));
  endtask

  task automatic drive(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic [REG_W-1:0] rd, input logic ut, input logic rw,
                       input logic ld, input logic fl);
    dec_valid = v; dec_rs = rs; dec_rt = rt; dec_rd = rd;
    dec_uses_rt = ut; dec_reg_write = rw; dec_mem_read = ld; flush = fl;
    #1;
    checkAll();
  endtask

  task automatic nop();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    logic   s;
    instr_t nw;
    s = expStall();
    if (s || flush || !dec_valid) begin
      nw = '0;
    end else begin
      nw.rs = dec_rs;
      nw.rt = dec_uses_rt ? dec_rt : '0;
      nw.rd = dec_rd;
      nw.wr = dec_reg_write;
      nw.ld = dec_mem_read;
    end
    @(posedge clk);
    slot[2] = slot[1];
    slot[1] = '0;
    slot[1].rd = slot[0].rd;
    slot[1].wr = slot[0].wr;
    slot[0] = nw;
    if (s && cnt < CNT_MAX) cnt++;
    #1;
  endtask

  initial begin
    resetModel();

    // Reset held with random decode activity: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      dec_valid = 1'($urandom); dec_rs = REG_W'($urandom); dec_rt = REG_W'($urandom);
      dec_rd = REG_W'($urandom); dec_uses_rt = 1'($urandom); dec_reg_write = 1'($urandom);
      dec_mem_read = 1'($urandom); flush = 1'($urandom);
      #4;
      checkAll();
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_cnt", 32'(stall_count), 32'd0);
    end
    dec_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    nop(); tick();
    nop(); tick();

    // add $3,$1,$2 ; sub $5,$3,$4
    drive(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0); tick();
    drive(1, 5'd3, 5'd4, 5'd5, 1, 1, 0, 0); tick();
    chk("exmem_fa", 32'(fa), 32'd2);
    chk("exmem_emrd", 32'(em_rd), 32'd3);
    chk("exmem_fb", 32'(fb), 32'd0);

    // add $3 ; add $3 ; or $6,$3,$3
    drive(1, 5'd1, 5'd1, 5'd3, 1, 1, 0, 0); tick();
    drive(1, 5'd1, 5'd1, 5'd3, 1, 1, 0, 0); tick();
    drive(1, 5'd3, 5'd3, 5'd6, 1, 1, 0, 0); tick();
    chk("dbl_fa", 32'(fa), 32'd2);
    chk("dbl_fb", 32'(fb), 32'd2);
    chk("dbl_mwrd", 32'(mw_rd), 32'd3);

    // lw $2 ; add $4,$2,$1
    nop(); tick(); nop(); tick();
    drive(1, 5'd1, 5'd2, 5'd2, 0, 1, 1, 0); tick();
    drive(1, 5'd2, 5'd1, 5'd4, 1, 1, 0, 0);
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_nostall", 32'(stall), 32'd0);
    chk("lu_bubble", 32'(ie_rs), 32'd0);
    chk("lu_cnt", 32'(stall_count), 32'd1);
    drive(1, 5'd2, 5'd1, 5'd4, 1, 1, 0, 0); tick();
    chk("lu_fa", 32'(fa), 32'd1);
    chk("lu_mwrd", 32'(mw_rd), 32'd2);
    chk("lu_fb", 32'(fb), 32'd0);

    // Writes to $0 never forward; loads to $0 never stall.
    drive(1, 5'd1, 5'd1, 5'd0, 1, 1, 0, 0); tick();
    drive(1, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0); tick();
    chk("zero_fa", 32'(fa), 32'd0);
    chk("zero_fb", 32'(fb), 32'd0);
    drive(1, 5'd1, 5'd0, 5'd0, 0, 1, 1, 0); tick();
    drive(1, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0);
    chk("zero_stall", 32'(stall), 32'd0);
    tick();
    // lw $7 ; addi $8,$9 with the unused rt field equal to 7
    drive(1, 5'd1, 5'd7, 5'd7, 0, 1, 1, 0); tick();
    drive(1, 5'd9, 5'd7, 5'd8, 0, 1, 0, 0);
    chk("nort_stall", 32'(stall), 32'd0);
    tick();
    chk("nort_iert", 32'(ie_rt), 32'd0);

    // lw $2 ; dependent arriving with flush
    drive(1, 5'd1, 5'd2, 5'd2, 0, 1, 1, 0); tick();
    drive(1, 5'd2, 5'd2, 5'd4, 1, 1, 0, 1);
    chk("flush_stall", 32'(stall), 32'd0);
    tick();
    chk("flush_bubble_rs", 32'(ie_rs), 32'd0);
    chk("flush_bubble_rd", 32'(em_rd), 32'd2);
    chk("flush_cnt", 32'(stall_count), 32'd1);

    // Back-to-back self-dependent loads (lw $2,0($2)) stall every other
    // cycle; run long enough to exceed 2^CNT_W+3 stalls.
    drive(1, 5'd2, 5'd0, 5'd2, 0, 1, 1, 0);
    for (int i = 0; i < 2 * ((1 << CNT_W) + 3) + 4; i++) begin
      tick();
      checkAll();
    end
    chk("sat_cnt", 32'(stall_count), 32'(CNT_MAX));

    // Randomized traffic over a small register set to provoke hazards.
    nop(); tick();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), REG_W'($urandom_range(0, 3)),
            REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      tick();
    end

    // Asynchronous reset in the middle of a stall.
    nop(); tick(); nop(); tick();
    drive(1, 5'd1, 5'd3, 5'd3, 0, 1, 1, 0); tick();
    drive(1, 5'd3, 5'd1, 5'd6, 1, 1, 0, 0);
    chk("mid_stall", 32'(stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkAll();
    chk("mid_rst_cnt", 32'(stall_count), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    dec_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkAll();
    drive(1, 5'd1, 5'd2, 5'd2, 0, 1, 1, 0); tick();
    drive(1, 5'd2, 5'd2, 5'd4, 1, 1, 0, 0);
    chk("post_rst_stall", 32'(stall), 32'd1);
    tick();
    chk("post_rst_cnt", 32'(stall_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
